// File: rtl/disp_pkg.sv
// Shared constants for the six-digit clock display scanner.
// Segment patterns are active-low, bit order g..a (bit 6 = g).
package disp_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [2:0] digit_idx_t;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // digit pattern lookup
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/disp_scan.sv
// Multiplexed six-digit HH:MM:SS scanner with frame snapshot and digit blinking.
// Optional build macro DISP_LEAD_ZERO_BLANK_EN blanks a leading zero in the hours tens digit.
module disp_scan
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] sec0,
  input  logic [2:0] sec1,
  input  logic [3:0] min0,
  input  logic [2:0] min1,
  input  logic [3:0] hr0,
  input  logic [1:0] hr1,
  input  logic       blink_tick,
  input  logic [5:0] blink_mask,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);

  logic [19:0] div_q, div_d;
  digit_idx_t  idx_q, idx_d;
  logic        ph_q, ph_d;
  logic [23:0] snap_q, snap_d;
  logic [5:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  cur_s;
  logic [6:0]  dec_s;
  logic        frame_end_s;

  bcd_to_seg7 u_dec (
    .bcd_i (cur_s),
    .seg_o (dec_s)
  );

  assign frame_end_s = (div_q == DIV_LAST) && (idx_q == 3'd5);

  // scan counters, blink phase and snapshot next state
  always_comb begin
    div_d  = div_q + 20'd1;
    idx_d  = idx_q;
    ph_d   = ph_q ^ blink_tick;
    snap_d = snap_q;
    if (div_q == DIV_LAST) begin
      div_d = 20'd0;
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end else begin
      idx_d = idx_q;
    end
    if (frame_end_s) begin
      snap_d = {2'b00, hr1, hr0, 1'b0, min1, min0, 1'b0, sec1, sec0};
    end else begin
      snap_d = snap_q;
    end
  end

  // digit currently being scanned, taken from the frame snapshot
  always_comb begin
    cur_s = 4'd0;
    case (idx_q)
      3'd0:    cur_s = snap_q[3:0];
      3'd1:    cur_s = snap_q[7:4];
      3'd2:    cur_s = snap_q[11:8];
      3'd3:    cur_s = snap_q[15:12];
      3'd4:    cur_s = snap_q[19:16];
      3'd5:    cur_s = snap_q[23:20];
      default: cur_s = 4'd0;
    endcase
  end

  // output next state; the first cycle of each slot blanks all anodes against ghosting
  always_comb begin
    an_d  = 6'b111111;
    seg_d = dec_s;
    dp_d  = 1'b1;
    if (div_q != 20'd0) begin
      an_d = ~(6'b000001 << idx_q);
    end else begin
      an_d = 6'b111111;
    end
    if (ph_q && blink_mask[idx_q]) begin
      seg_d = SEG_OFF;
`ifdef DISP_LEAD_ZERO_BLANK_EN
    end else if ((idx_q == 3'd5) && (cur_s == 4'd0)) begin
      seg_d = SEG_OFF;
`endif
    end else begin
      seg_d = dec_s;
    end
    if (((idx_q == 3'd2) || (idx_q == 3'd4)) && !ph_q) begin
      dp_d = 1'b0;
    end else begin
      dp_d = 1'b1;
    end
  end

  // state and registered outputs; clr wins over tick and capture
  always_ff @(posedge clk) begin
    if (clr) begin
      div_q  <= 20'd0;
      idx_q  <= 3'd0;
      ph_q   <= 1'b0;
      snap_q <= 24'd0;
      an_q   <= 6'b111111;
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      ph_q   <= ph_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed self-checking bench for disp_scan with SCAN_DIV=4 (24 cycles per frame).
module tb_disp_scan;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S6   = 7'b0000010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] OFF  = 7'b1111111;
`ifdef DISP_LEAD_ZERO_BLANK_EN
  localparam logic [6:0] HR1Z = OFF;
`else
  localparam logic [6:0] HR1Z = S0;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] sec0, min0, hr0;
  logic [2:0] sec1, min1;
  logic [1:0] hr1;
  logic       blink_tick;
  logic [5:0] blink_mask;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_total = 0;
  int n_bad   = 0;

  disp_scan #(.SCAN_DIV(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .sec0       (sec0),
    .sec1       (sec1),
    .min0       (min0),
    .min1       (min1),
    .hr0        (hr0),
    .hr1        (hr1),
    .blink_tick (blink_tick),
    .blink_mask (blink_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s got=%b want=%b", tag, obs, exp_v);
    end
  endtask

  // segs holds the expected pattern per digit, digit k at [7k +: 7]
  task automatic run_slots(input int start, input int n, input logic ph_e,
                           input logic [41:0] segs, input logic pulse_last);
    int s, d, k;
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    for (int i = 0; i < n; i++) begin
      s = start + i;
      d = s % 4;
      k = s / 4;
      blink_tick = pulse_last && (i == n - 1);
      @(posedge clk);
      #1;
      blink_tick = 1'b0;
      e_an  = (d == 0) ? 6'b111111 : ~(6'b000001 << k);
      e_seg = (ph_e && blink_mask[k]) ? OFF : segs[k*7 +: 7];
      e_dp  = ((k == 2 || k == 4) && !ph_e) ? 1'b0 : 1'b1;
      chk($sformatf("an_s%0d", s),  {2'b00, an},  {2'b00, e_an});
      chk($sformatf("seg_s%0d", s), {1'b0, seg},  {1'b0, e_seg});
      chk($sformatf("dp_s%0d", s),  {7'd0, dp},   {7'd0, e_dp});
    end
  endtask

  initial begin
    clr = 1'b1; blink_tick = 1'b0; blink_mask = 6'b000000;
    sec0 = 4'd0; sec1 = 3'd0; min0 = 4'd0; min1 = 3'd0; hr0 = 4'd0; hr1 = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an",  {2'b00, an}, 8'h3F);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_dp",  {7'd0, dp},  8'h01);
    clr = 1'b0;

    // frame 0: all-zero snapshot; inputs changed mid-frame stay hidden
    run_slots(0, 2, 1'b0, {HR1Z, S0, S0, S0, S0, S0}, 1'b0);
    sec0 = 4'd7; min1 = 3'd6; hr0 = 4'd12;
    run_slots(2, 22, 1'b0, {HR1Z, S0, S0, S0, S0, S0}, 1'b0);

    // frame 1: new snapshot, blink armed, phase toggles on last cycle
    blink_mask = 6'b000011;
    run_slots(0, 24, 1'b0, {HR1Z, DASH, S6, S0, S0, S7}, 1'b1);

    // frame 2: phase 1, digits 0/1 blanked, dots off
    hr1 = 2'd1;
    run_slots(0, 24, 1'b1, {HR1Z, DASH, S6, S0, S0, S7}, 1'b1);

    // frame 3: phase back to 0, hr1=1 shown
    run_slots(0, 24, 1'b0, {S1, DASH, S6, S0, S0, S7}, 1'b0);

    // frame 4 interrupted by clr inside slot 3 together with a blink tick
    run_slots(0, 14, 1'b0, {S1, DASH, S6, S0, S0, S7}, 1'b0);
    clr = 1'b1; blink_tick = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_an",  {2'b00, an}, 8'h3F);
    chk("clr_seg", {1'b0, seg}, 8'h7F);
    chk("clr_dp",  {7'd0, dp},  8'h01);
    clr = 1'b0; blink_tick = 1'b0;
    run_slots(0, 24, 1'b0, {HR1Z, S0, S0, S0, S0, S0}, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
